// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a shared FIFO write port; a grant holds for up to MAX_BURST beats.
// Optional per-requester beat statistics are enabled by defining FIFO_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no owner; pick next valid requester round-robin from rr_ptr (no beat this cycle)
// BURST | owner streams beats into the FIFO until MAX_BURST beats or its valid drops
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CNT_W     = 16
) (
    input  logic                       wr_clk,
    input  logic                       res_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]   beat_cnt_o
`endif
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    if (NUM_REQ < 2 || MAX_BURST < 1 || CNT_W < 1) begin : g_bad_params
        $error("fifo_wr_arbiter: illegal parameter combination");
    end

    state_t            state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   next_ptr;
    logic [BC_W-1:0]   beat_cnt;
    logic              any_valid;
    logic              beat;
    logic [WIDTH-1:0]  data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        pick      = rr_ptr;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = ID_W'(idx);
            end
        end
    end

    assign next_ptr   = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);

    // Qualified by the current full flag, so a write into a full FIFO cannot happen.
    assign beat       = res_n && (state == BURST) && req_valid[owner] && !fifo_full;
    assign fifo_wr_en = beat;
    assign req_ready  = beat ? (NUM_REQ'(1) << owner) : '0;
    assign fifo_wdata = res_n ? data_arr[owner] : '0;

    always_ff @(posedge wr_clk) begin
        if (!res_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner    <= pick;
                        grant_id <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (!fifo_full) begin
                        if (req_valid[owner]) begin
                            beat_cnt <= beat_cnt + BC_W'(1);
                            if (beat_cnt == LAST_BEAT) begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                rr_ptr <= next_ptr;
                            end
                        end else begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] stat_cnt [NUM_REQ];

    always_ff @(posedge wr_clk) begin
        if (!res_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (beat && (stat_cnt[owner] != '1)) begin
            stat_cnt[owner] <= stat_cnt[owner] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        assign beat_cnt_o[g*CNT_W +: CNT_W] = stat_cnt[g];
    end
`endif

endmodule
